// File: rtl/hilo_multdiv_ctrl.sv
// HI/LO register owner and multiply/divide scheduler for the execute stage.
// Issues work to an external fixed-latency multiplier and an iterative
// divider, writes HI/LO back on completion, and cancels work on flush.
module hilo_multdiv_ctrl #(
   parameter int MUL_LAT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        mul_start,
   output logic        mul_signed,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [31:0] mul_hi,
   input  logic [31:0] mul_lo,
   output logic        div_start,
   output logic        div_signed,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   input  logic        div_done,
   input  logic [31:0] div_hi,
   input  logic [31:0] div_lo,
   output logic        div_abort
);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [3:0] LAT      = 4'(MUL_LAT);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        sgn_q, sgn_d;
   logic        first_q, first_d;   // high in the first cycle of MUL/DIV
   logic        accept;

   assign req_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign accept     = req_valid & req_ready & ~flush;
   assign hi         = hi_q;
   assign lo         = lo_q;
   assign mul_a      = a_q;
   assign mul_b      = b_q;
   assign div_a      = a_q;
   assign div_b      = b_q;
   assign mul_signed = sgn_q;
   assign div_signed = sgn_q;
   assign mul_start  = (state_q == MUL) & first_q;
   assign div_start  = (state_q == DIV) & first_q;
   // reset overrides flush, so no abort is sent while resetting
   assign div_abort  = (state_q == DIV) & flush & ~reset;

   // next-state, operand capture and HI/LO writeback
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      first_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (req_op)
                  OP_MULT, OP_MULTU: begin
                     a_d     = req_a;
                     b_d     = req_b;
                     sgn_d   = (req_op == OP_MULT);
                     cnt_d   = LAT;
                     first_d = 1'b1;
                     state_d = MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     // divide by zero leaves HI/LO untouched and never
                     // reaches the divider
                     if (req_b != 32'd0) begin
                        a_d     = req_a;
                        b_d     = req_b;
                        sgn_d   = (req_op == OP_DIV);
                        first_d = 1'b1;
                        state_d = DIV;
                     end
                  end
                  OP_MTHI: hi_d = req_a;
                  OP_MTLO: lo_d = req_a;
                  default: ;
               endcase
            end
         end
         MUL: begin
            cnt_d = cnt_q - 4'd1;
            if (flush) begin
               state_d = IDLE;
            end else if (cnt_q == 4'd1) begin
               hi_d    = mul_hi;
               lo_d    = mul_lo;
               state_d = IDLE;
            end
         end
         DIV: begin
            // a done coincident with the start pulse is stale
            if (flush) begin
               state_d = IDLE;
            end else if (div_done && !first_q) begin
               hi_d    = div_hi;
               lo_d    = div_lo;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         sgn_q   <= 1'b0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         first_q <= first_d;
      end
   end

endmodule

// File: tb/tb_hilo_multdiv_ctrl.sv
// Bench for hilo_multdiv_ctrl with a behavioural multiplier and a
// 33-cycle divider; results are checked against a scoreboard queue.
module tb_hilo_multdiv_ctrl;

   logic        clk = 1'b0;
   logic        reset, flush, req_valid, req_ready, busy;
   logic [2:0]  req_op;
   logic [31:0] req_a, req_b, hi, lo;
   logic        mul_start, mul_signed, div_start, div_signed, div_done, div_abort;
   logic [31:0] mul_a, mul_b, mul_hi, mul_lo, div_a, div_b, div_hi, div_lo;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   hilo_multdiv_ctrl #(.MUL_LAT(4)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .busy(busy), .hi(hi), .lo(lo),
      .mul_start(mul_start), .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b),
      .mul_hi(mul_hi), .mul_lo(mul_lo),
      .div_start(div_start), .div_signed(div_signed), .div_a(div_a), .div_b(div_b),
      .div_done(div_done), .div_hi(div_hi), .div_lo(div_lo), .div_abort(div_abort)
   );

   // multiplier model: operands are held stable, so the product is valid
   // well before the controller samples it
   logic [63:0] sprod, uprod;
   assign sprod  = 64'($signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b}));
   assign uprod  = {32'd0, mul_a} * {32'd0, mul_b};
   assign mul_hi = mul_signed ? sprod[63:32] : uprod[63:32];
   assign mul_lo = mul_signed ? sprod[31:0]  : uprod[31:0];

   // divider model (unsigned only is exercised): done 33 cycles after start
   int          dcnt;
   logic [31:0] dq, dr;
   logic        force_done;
   always @(posedge clk) begin
      if (reset || div_abort) dcnt <= 0;
      else if (div_start) begin
         dcnt <= 33;
         dq   <= div_a / div_b;
         dr   <= div_a % div_b;
      end else if (dcnt != 0) dcnt <= dcnt - 1;
   end
   assign div_done = (dcnt == 1) | force_done;
   assign div_hi   = force_done ? 32'hDEAD_BEEF : dr;
   assign div_lo   = force_done ? 32'hCAFE_F00D : dq;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1; flush = 0; req_valid = 0; req_op = 3'd6; req_a = 0; req_b = 0;
      force_done = 0;
      step(); step();
      reset = 0;
      n_chk++; if (hi !== 32'd0 || lo !== 32'd0) begin
         n_fail++; $display("FAIL reset_hilo hi=%h lo=%h want 0/0", hi, lo);
      end
      n_chk++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready ready=%b busy=%b want 1/0", req_ready, busy);
      end
      n_chk++; if ({mul_start, div_start, div_abort} !== 3'b000 || mul_a !== 32'd0 || div_b !== 32'd0) begin
         n_fail++; $display("FAIL reset_outs strobes=%b%b%b mul_a=%h div_b=%h want 0",
                            mul_start, div_start, div_abort, mul_a, div_b);
      end
   endtask

   task automatic test_mthi_mtlo();
      req_valid = 1; req_op = 3'd4; req_a = 32'h1234_5678;
      step();
      n_chk++; if (hi !== 32'h1234_5678 || req_ready !== 1'b1) begin
         n_fail++; $display("FAIL mthi hi=%h ready=%b want 12345678/1", hi, req_ready);
      end
      req_op = 3'd5; req_a = 32'h9ABC_DEF0;
      sb.push_back('{hi: 32'h1234_5678, lo: 32'h9ABC_DEF0});
      step();
      req_valid = 0;
      e = sb.pop_front();
      n_chk++; if (hi !== e.hi || lo !== e.lo || req_ready !== 1'b1) begin
         n_fail++; $display("FAIL mtlo hi=%h lo=%h ready=%b want %h/%h/1", hi, lo, req_ready, e.hi, e.lo);
      end
   endtask

   // issue a multiply and wait for its writeback; returns busy length and start count
   task automatic run_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lowcnt, output int starts, output int sgn);
      req_valid = 1; req_op = op; req_a = a; req_b = b;
      step();
      req_valid = 0;
      lowcnt = 0; starts = 0; sgn = mul_signed;
      for (int i = 0; i < 40 && !req_ready; i++) begin
         lowcnt++;
         if (mul_start) starts++;
         step();
      end
   endtask

   task automatic test_mult();
      int lc, st, sg;
      sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFA});
      run_mul(3'd0, 32'hFFFF_FFFE, 32'd3, lc, st, sg);
      e = sb.pop_front();
      n_chk++; if (lc != 4) begin
         n_fail++; $display("FAIL mult_latency busy_cycles=%0d want 4", lc);
      end
      n_chk++; if (st != 1 || sg != 1) begin
         n_fail++; $display("FAIL mult_start starts=%0d signed=%0d want 1/1", st, sg);
      end
      n_chk++; if (hi !== e.hi || lo !== e.lo) begin
         n_fail++; $display("FAIL mult_result hi=%h lo=%h want %h/%h", hi, lo, e.hi, e.lo);
      end
   endtask

   task automatic test_divu();
      int bc = 0, st = 0;
      sb.push_back('{hi: 32'd2, lo: 32'd14});
      req_valid = 1; req_op = 3'd3; req_a = 32'd100; req_b = 32'd7;
      step();
      req_valid = 0;
      n_chk++; if (div_signed !== 1'b0) begin
         n_fail++; $display("FAIL divu_signed got=%b want 0", div_signed);
      end
      for (int i = 0; i < 200 && busy; i++) begin
         bc++;
         if (div_start) st++;
         step();
      end
      e = sb.pop_front();
      n_chk++; if (bc != 34 || st != 1) begin
         n_fail++; $display("FAIL divu_timing busy=%0d starts=%0d want 34/1", bc, st);
      end
      n_chk++; if (hi !== e.hi || lo !== e.lo) begin
         n_fail++; $display("FAIL divu_result hi=%h lo=%h want %h/%h", hi, lo, e.hi, e.lo);
      end
   endtask

   task automatic test_div_zero();
      req_valid = 1; req_op = 3'd4; req_a = 32'hAAAA_5555; step();
      req_op = 3'd5; step();
      req_op = 3'd2; req_a = 32'd5; req_b = 32'd0; step();
      req_valid = 0;
      n_chk++; if (req_ready !== 1'b1 || div_start !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL divzero_state ready=%b div_start=%b busy=%b want 1/0/0",
                            req_ready, div_start, busy);
      end
      n_chk++; if (hi !== 32'hAAAA_5555 || lo !== 32'hAAAA_5555) begin
         n_fail++; $display("FAIL divzero_hilo hi=%h lo=%h want aaaa5555", hi, lo);
      end
   endtask

   task automatic test_div_flush();
      req_valid = 1; req_op = 3'd3; req_a = 32'd1000; req_b = 32'd3;
      step();
      req_valid = 0;
      for (int i = 0; i < 10; i++) step();
      flush = 1; #1;
      n_chk++; if (div_abort !== 1'b1) begin
         n_fail++; $display("FAIL divflush_abort got=%b want 1", div_abort);
      end
      step();
      flush = 0; #1;
      n_chk++; if (div_abort !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++; $display("FAIL divflush_idle abort=%b ready=%b want 0/1", div_abort, req_ready);
      end
      force_done = 1; step(); force_done = 0; step();
      n_chk++; if (hi !== 32'hAAAA_5555 || lo !== 32'hAAAA_5555) begin
         n_fail++; $display("FAIL divflush_hilo hi=%h lo=%h want aaaa5555", hi, lo);
      end
   endtask

   task automatic test_back_to_back();
      int lc, st, sg;
      req_valid = 1; req_op = 3'd0; req_a = 32'd7; req_b = 32'd9;
      step();
      req_valid = 0;
      step(); step(); step();   // now in the counter==1 cycle
      flush = 1;
      step();
      flush = 0;
      n_chk++; if (req_ready !== 1'b1 || hi !== 32'hAAAA_5555 || lo !== 32'hAAAA_5555) begin
         n_fail++; $display("FAIL mulflush ready=%b hi=%h lo=%h want 1/aaaa5555", req_ready, hi, lo);
      end
      sb.push_back('{hi: 32'd1, lo: 32'hFFFF_FFFE});
      run_mul(3'd1, 32'hFFFF_FFFF, 32'd2, lc, st, sg);
      e = sb.pop_front();
      n_chk++; if (lc != 4 || st != 1 || sg != 0) begin
         n_fail++; $display("FAIL multu_ctl busy=%0d starts=%0d signed=%0d want 4/1/0", lc, st, sg);
      end
      n_chk++; if (hi !== e.hi || lo !== e.lo) begin
         n_fail++; $display("FAIL multu_result hi=%h lo=%h want %h/%h", hi, lo, e.hi, e.lo);
      end
      // flush in IDLE drops a concurrent request
      req_valid = 1; req_op = 3'd4; req_a = 32'h5555_0000; flush = 1;
      step();
      req_valid = 0; flush = 0;
      n_chk++; if (hi !== e.hi) begin
         n_fail++; $display("FAIL idleflush hi=%h want %h", hi, e.hi);
      end
   endtask

   task automatic test_reset_mid_div();
      req_valid = 1; req_op = 3'd3; req_a = 32'd50; req_b = 32'd5;
      step();
      req_valid = 0;
      step();
      reset = 1; flush = 1; #1;
      n_chk++; if (div_abort !== 1'b0) begin
         n_fail++; $display("FAIL rstdiv_abort got=%b want 0", div_abort);
      end
      step();
      reset = 0; flush = 0;
      n_chk++; if (req_ready !== 1'b1 || hi !== 32'd0 || lo !== 32'd0) begin
         n_fail++; $display("FAIL rstdiv_state ready=%b hi=%h lo=%h want 1/0/0", req_ready, hi, lo);
      end
   endtask

   initial begin
      test_reset();
      test_mthi_mtlo();
      test_mult();
      test_divu();
      test_div_zero();
      test_div_flush();
      test_back_to_back();
      test_reset_mid_div();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
